mod_matrix_accum: RTL
=====================

MOD_MATRIX_ACCUM -- requirements
Module: mod_matrix_accum

Interface
REQ-001 SHALL have parameter INPUTS, default 8: number of modulation sources and destinations (1..255).
REQ-002 SHALL have parameter DWIDTH, default 16: signed sample width of sources and outputs.
REQ-003 SHALL have parameter GWIDTH, default 8: signed routing-gain width, format Q1.(GWIDTH-1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a matrix frame.
REQ-007 SHALL have port select, output, 8 bits: source index driven to the upstream source multiplexer.
REQ-008 SHALL have port src_data, input, DWIDTH bits: the multiplexer output for the current select, combinational from select.
REQ-009 SHALL have ports gain_we (1 bit), gain_dst (8 bits), gain_src (8 bits) and gain_wdata (GWIDTH bits), inputs: routing-gain table write port.
REQ-010 SHALL have ports mod_data (DWIDTH bits) and mod_dest (8 bits), outputs: per-destination modulation sum and its destination index.
REQ-011 SHALL have port mod_valid, output, and port mod_ready, input: valid/ready handshake for mod_data and mod_dest.
REQ-012 SHALL have outputs busy (1 bit, high outside IDLE) and done (1 bit, one-cycle pulse at frame end).

Function
REQ-013 SHALL hold an INPUTS x INPUTS signed gain table indexed [dst][src]; a write is visible to reads from the following cycle.
REQ-014 SHALL implement FSM states IDLE, ACCUM and EMIT.
REQ-015 In IDLE, start SHALL set dst=0, src=0 and acc=0, and go to ACCUM; start outside IDLE SHALL be ignored.
REQ-016 In ACCUM, select SHALL equal src, and each cycle SHALL update acc to acc + src_data*gain[dst][src] (full-precision signed), then increment src.
REQ-017 acc SHALL be DWIDTH+GWIDTH+clog2(INPUTS) bits wide so that no intermediate overflow occurs.
REQ-018 On the cycle that src=INPUTS-1 is accumulated, the FSM SHALL go to EMIT, with mod_valid high from the next cycle.
REQ-019 mod_data SHALL be acc arithmetic-shifted right by GWIDTH-1 and saturated to the signed DWIDTH range; mod_dest SHALL equal dst.
REQ-020 In EMIT, mod_data, mod_dest and mod_valid SHALL be held stable until mod_valid and mod_ready are both high.
REQ-021 On that handshake, if dst<INPUTS-1, the block SHALL increment dst, clear acc and src, and return to ACCUM.
REQ-022 On that handshake, if dst=INPUTS-1, the block SHALL return to IDLE and pulse done for one cycle.
REQ-023 select SHALL be 0 in IDLE and SHALL hold INPUTS-1 in EMIT.
REQ-024 With mod_ready held high, a frame SHALL take exactly INPUTS*(INPUTS+1) cycles from start to done.
REQ-025 A gain write in the same cycle as a read of the same entry SHALL return the old value.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE, select=0, mod_valid=0, mod_data=0, mod_dest=0, busy=0 and done=0, and clear acc, src and dst.
REQ-027 Reset SHALL NOT clear the gain table; its contents are undefined until written.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further mod_valid or done.

Structure
REQ-029 The FSM state enum and the accumulator-width function SHALL reside in a shared package, fm_matrix_pkg.
REQ-030 The gain table SHALL be a sub-module, gain_table_ram (one write port, one asynchronous read port).

Verification
REQ-031 Bench SHALL write gain[0][3]=0x40 (0.5), all other gains 0, set source 3=1000 and pulse start -> mod_dest 0 gives 500, all other destinations give 0, and done arrives at cycle 72.
REQ-032 Bench SHALL set all gains 0x7F and all sources 0x7FFF -> every mod_data saturates to 0x7FFF.
REQ-033 Bench SHALL set all gains 0x80 (-1.0) and all sources 0x7FFF -> every mod_data saturates to 0x8000.
REQ-034 Bench SHALL hold mod_ready low for 5 cycles at destination 2 -> mod_data and mod_dest stay stable and the frame extends by 5 cycles.
REQ-035 Bench SHALL pulse start again while busy and assert reset_n low at cycle 20 -> the second start is ignored, outputs go to reset values immediately, and no done follows.

Source files
------------

// File: rtl/fm_matrix_pkg.sv
// Shared types and width helpers for the modulation-matrix accumulator.
package fm_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } fsm_state_t;

  // Worst case is n full-scale products summed, hence the extra clog2(n) bits.
  function automatic int acc_width(input int dw, input int gw, input int n);
    return dw + gw + $clog2(n);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gain_table_ram.sv
// Routing-gain table [dst][src]: one synchronous write port, one asynchronous read port.
// Latency: a write is visible to reads from the next cycle; a same-cycle read returns the old value.
// Backpressure: none, writes are always accepted; out-of-range addresses are dropped.
module gain_table_ram
  import fm_matrix_pkg::*;
#(
  parameter int INPUTS = 8,
  parameter int GWIDTH = 8
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [7:0]                       wr_dst,
  input  logic [7:0]                       wr_src,
  input  logic [GWIDTH-1:0]                wr_data,
  input  logic [idx_width(INPUTS)-1:0]     rd_dst,
  input  logic [idx_width(INPUTS)-1:0]     rd_src,
  output logic [GWIDTH-1:0]                rd_data
);

  localparam int         IW   = idx_width(INPUTS);
  localparam logic [7:0] LAST = 8'(INPUTS - 1);

  logic [GWIDTH-1:0] mem [INPUTS][INPUTS];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_dst <= LAST) && (wr_src <= LAST)) begin
      mem[wr_dst[IW-1:0]][wr_src[IW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_dst][rd_src];

endmodule

// File: rtl/mod_matrix_accum.sv
// Modulation matrix: per destination, sums src_data*gain over all sources and emits a saturated sample.
// Latency: INPUTS accumulate cycles plus one emit cycle per destination; INPUTS*(INPUTS+1) per frame.
// Backpressure: mod_data/mod_dest/mod_valid hold in EMIT until mod_ready; the frame stalls meanwhile.
module mod_matrix_accum
  import fm_matrix_pkg::*;
#(
  parameter int INPUTS = 8,
  parameter int DWIDTH = 16,
  parameter int GWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [7:0]        select,
  input  logic [DWIDTH-1:0] src_data,
  input  logic              gain_we,
  input  logic [7:0]        gain_dst,
  input  logic [7:0]        gain_src,
  input  logic [GWIDTH-1:0] gain_wdata,
  output logic [DWIDTH-1:0] mod_data,
  output logic [7:0]        mod_dest,
  output logic              mod_valid,
  input  logic              mod_ready,
  output logic              busy,
  output logic              done
);

  localparam int         AW   = acc_width(DWIDTH, GWIDTH, INPUTS);
  localparam int         PW   = DWIDTH + GWIDTH;
  localparam int         IW   = idx_width(INPUTS);
  localparam logic [7:0] LAST = 8'(INPUTS - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  fsm_state_t                 state, state_nxt;
  logic [7:0]                 src, src_nxt, dst, dst_nxt;
  logic signed [AW-1:0]       acc, acc_nxt, acc_sum, acc_shr;
  logic signed [PW-1:0]       prod;
  logic signed [DWIDTH-1:0]   sample, sat_val;
  logic [GWIDTH-1:0]          gain_raw;
  logic signed [GWIDTH-1:0]   gain;
  logic [DWIDTH-1:0]          mod_data_nxt;
  logic [7:0]                 mod_dest_nxt;
  logic                       mod_valid_nxt, done_nxt;

  gain_table_ram #(
    .INPUTS (INPUTS),
    .GWIDTH (GWIDTH)
  ) u_gain_table (
    .clk     (clk),
    .wr_en   (gain_we),
    .wr_dst  (gain_dst),
    .wr_src  (gain_src),
    .wr_data (gain_wdata),
    .rd_dst  (dst[IW-1:0]),
    .rd_src  (src[IW-1:0]),
    .rd_data (gain_raw)
  );

  assign sample  = src_data;
  assign gain    = gain_raw;
  assign prod    = sample * gain;
  assign acc_sum = acc + AW'(prod);
  // Drop the Q1.(GWIDTH-1) fraction, then clamp into the output sample range.
  assign acc_shr = acc_sum >>> (GWIDTH - 1);

  always_comb begin
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[DWIDTH-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[DWIDTH-1:0];
    else                        sat_val = acc_shr[DWIDTH-1:0];
  end

  // src rests at LAST through EMIT, so only IDLE needs forcing.
  assign select = (state == IDLE) ? 8'd0 : src;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    src_nxt       = src;
    dst_nxt       = dst;
    acc_nxt       = acc;
    mod_valid_nxt = mod_valid;
    mod_data_nxt  = mod_data;
    mod_dest_nxt  = mod_dest;
    done_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          src_nxt   = 8'd0;
          dst_nxt   = 8'd0;
          acc_nxt   = '0;
        end
      end
      ACCUM: begin
        acc_nxt = acc_sum;
        if (src == LAST) begin
          state_nxt     = EMIT;
          mod_valid_nxt = 1'b1;
          mod_data_nxt  = sat_val;
          mod_dest_nxt  = dst;
        end else begin
          src_nxt = src + 8'd1;
        end
      end
      EMIT: begin
        if (mod_ready) begin
          mod_valid_nxt = 1'b0;
          if (dst == LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ACCUM;
            dst_nxt   = dst + 8'd1;
            src_nxt   = 8'd0;
            acc_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      src       <= 8'd0;
      dst       <= 8'd0;
      acc       <= '0;
      mod_valid <= 1'b0;
      mod_data  <= '0;
      mod_dest  <= 8'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      src       <= src_nxt;
      dst       <= dst_nxt;
      acc       <= acc_nxt;
      mod_valid <= mod_valid_nxt;
      mod_data  <= mod_data_nxt;
      mod_dest  <= mod_dest_nxt;
      done      <= done_nxt;
    end
  end

endmodule
